// File: rtl/multicycle_pkg.sv
// Shared encodings for the multicycle control path: FSM states, opcodes and
// the select-line encodings used by the datapath muxes and ALU control.
package multicycle_pkg;

    typedef enum logic [3:0] {
        ST_FETCH     = 4'd0,
        ST_DECODE    = 4'd1,
        ST_MEM_ADDR  = 4'd2,
        ST_MEM_READ  = 4'd3,
        ST_MEM_WB    = 4'd4,
        ST_MEM_WRITE = 4'd5,
        ST_R_EXEC    = 4'd6,
        ST_R_WB      = 4'd7,
        ST_ADDI_EXEC = 4'd8,
        ST_ADDI_WB   = 4'd9,
        ST_BRANCH    = 4'd10,
        ST_JUMP      = 4'd11
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_ADDI  = 6'h08;

    localparam logic [1:0] ALUB_REG_B   = 2'd0;
    localparam logic [1:0] ALUB_FOUR    = 2'd1;
    localparam logic [1:0] ALUB_IMM     = 2'd2;
    localparam logic [1:0] ALUB_IMM_SH2 = 2'd3;

    localparam logic [1:0] ALUOP_ADD   = 2'd0;
    localparam logic [1:0] ALUOP_SUB   = 2'd1;
    localparam logic [1:0] ALUOP_FUNCT = 2'd2;

    localparam logic [1:0] PCSRC_ALU    = 2'd0;
    localparam logic [1:0] PCSRC_ALUOUT = 2'd1;
    localparam logic [1:0] PCSRC_JUMP   = 2'd2;

endpackage

// File: rtl/multicycle_control_fsm.sv
// Main sequencing controller of the multicycle datapath: steps each instruction
// through its states, drives all select lines, counts retirements.
module multicycle_control_fsm
    import multicycle_pkg::*;
#(
    parameter int CNT_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [5:0]           opcode,
    input  logic                 mem_ready,
    output logic                 pc_write,
    output logic                 pc_write_cond,
    output logic                 i_or_d,
    output logic                 mem_read,
    output logic                 mem_write,
    output logic                 ir_write,
    output logic                 mem_to_reg,
    output logic                 reg_dst,
    output logic                 reg_write,
    output logic                 alu_src_a,
    output logic [1:0]           alu_src_b,
    output logic [1:0]           alu_op,
    output logic [1:0]           pc_source,
    output logic [CNT_WIDTH-1:0] retired,
    output logic                 illegal
);

    localparam logic [CNT_WIDTH-1:0] CNT_ONE = 1;

    state_t state;
    state_t state_next;
    logic   retire;
    logic   illegal_hit;

    // NOTE: sequential state uses non-blocking assignments so every register
    // updates from the same pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= ST_FETCH;
            retired <= '0;
            illegal <= 1'b0;
        end else begin
            state <= state_next;
            if (retire)      retired <= retired + CNT_ONE;
            if (illegal_hit) illegal <= 1'b1;
        end
    end

    // NOTE: every combinational output gets a default first, so no path
    // through the case can leave a value held (no inferred latch).
    always_comb begin
        state_next  = state;
        retire      = 1'b0;
        illegal_hit = 1'b0;
        case (state)
            ST_FETCH: if (mem_ready) state_next = ST_DECODE;
            ST_DECODE: begin
                case (opcode)
                    OP_LW, OP_SW: state_next = ST_MEM_ADDR;
                    OP_RTYPE:     state_next = ST_R_EXEC;
                    OP_ADDI:      state_next = ST_ADDI_EXEC;
                    OP_BEQ:       state_next = ST_BRANCH;
                    OP_J:         state_next = ST_JUMP;
                    default: begin
                        state_next  = ST_FETCH;
                        illegal_hit = 1'b1;
                    end
                endcase
            end
            ST_MEM_ADDR:  state_next = (opcode == OP_LW) ? ST_MEM_READ : ST_MEM_WRITE;
            ST_MEM_READ:  if (mem_ready) state_next = ST_MEM_WB;
            ST_MEM_WRITE: begin
                if (mem_ready) begin
                    state_next = ST_FETCH;
                    retire     = 1'b1;
                end
            end
            ST_R_EXEC:    state_next = ST_R_WB;
            ST_ADDI_EXEC: state_next = ST_ADDI_WB;
            ST_MEM_WB, ST_R_WB, ST_ADDI_WB, ST_BRANCH, ST_JUMP: begin
                state_next = ST_FETCH;
                retire     = 1'b1;
            end
            default:      state_next = ST_FETCH;
        endcase
    end

    always_comb begin
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        i_or_d        = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        ir_write      = 1'b0;
        mem_to_reg    = 1'b0;
        reg_dst       = 1'b0;
        reg_write     = 1'b0;
        alu_src_a     = 1'b0;
        alu_src_b     = ALUB_REG_B;
        alu_op        = ALUOP_ADD;
        pc_source     = PCSRC_ALU;
        case (state)
            ST_FETCH: begin
                // Fetch commits only on the cycle memory delivers the word.
                mem_read  = 1'b1;
                alu_src_b = ALUB_FOUR;
                ir_write  = mem_ready & ~reset;
                pc_write  = mem_ready & ~reset;
            end
            ST_DECODE:    alu_src_b = ALUB_IMM_SH2;
            ST_MEM_ADDR: begin
                alu_src_a = 1'b1;
                alu_src_b = ALUB_IMM;
            end
            ST_MEM_READ: begin
                mem_read = 1'b1;
                i_or_d   = 1'b1;
            end
            ST_MEM_WB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
            end
            ST_MEM_WRITE: begin
                mem_write = 1'b1;
                i_or_d    = 1'b1;
            end
            ST_R_EXEC: begin
                alu_src_a = 1'b1;
                alu_op    = ALUOP_FUNCT;
            end
            ST_R_WB: begin
                reg_write = 1'b1;
                reg_dst   = 1'b1;
            end
            ST_ADDI_EXEC: begin
                alu_src_a = 1'b1;
                alu_src_b = ALUB_IMM;
            end
            ST_ADDI_WB:   reg_write = 1'b1;
            ST_BRANCH: begin
                alu_src_a     = 1'b1;
                alu_op        = ALUOP_SUB;
                pc_write_cond = 1'b1;
                pc_source     = PCSRC_ALUOUT;
            end
            ST_JUMP: begin
                pc_write  = 1'b1;
                pc_source = PCSRC_JUMP;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Randomized scoreboard bench: an instruction-level model predicts every
// cycle's control word, retired count and illegal flag for two counter widths.
module tb_multicycle_control_fsm;

    typedef enum int {
        P_FETCH, P_DECODE, P_MEM_ADDR, P_MEM_READ, P_MEM_WB, P_MEM_WRITE,
        P_R_EXEC, P_R_WB, P_ADDI_EXEC, P_ADDI_WB, P_BRANCH, P_JUMP
    } phase_t;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       i_or_d;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       mem_to_reg;
        logic       reg_dst;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] pc_source;
    } ctrl_t;

    typedef struct {
        ctrl_t       ctrl;
        logic [31:0] retired;
        logic        illegal;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    logic [5:0] opcode;
    logic mem_ready;

    logic pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write;
    logic mem_to_reg, reg_dst, reg_write, alu_src_a;
    logic [1:0] alu_src_b, alu_op, pc_source;
    logic [31:0] retired;
    logic illegal;

    logic pc_write4, pc_write_cond4, i_or_d4, mem_read4, mem_write4, ir_write4;
    logic mem_to_reg4, reg_dst4, reg_write4, alu_src_a4;
    logic [1:0] alu_src_b4, alu_op4, pc_source4;
    logic [3:0] retired4;
    logic illegal4;

    exp_t q[$];
    int   n_vec = 0;
    int   n_err = 0;
    int   model_cnt;
    logic model_ill;
    logic [5:0] legal_ops [6] = '{6'h00, 6'h23, 6'h2B, 6'h04, 6'h02, 6'h08};

    always #5 clk = ~clk;

    multicycle_control_fsm dut (
        .clk(clk), .reset(reset), .opcode(opcode), .mem_ready(mem_ready),
        .pc_write(pc_write), .pc_write_cond(pc_write_cond), .i_or_d(i_or_d),
        .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
        .mem_to_reg(mem_to_reg), .reg_dst(reg_dst), .reg_write(reg_write),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
        .pc_source(pc_source), .retired(retired), .illegal(illegal)
    );

    multicycle_control_fsm #(.CNT_WIDTH(4)) dut4 (
        .clk(clk), .reset(reset), .opcode(opcode), .mem_ready(mem_ready),
        .pc_write(pc_write4), .pc_write_cond(pc_write_cond4), .i_or_d(i_or_d4),
        .mem_read(mem_read4), .mem_write(mem_write4), .ir_write(ir_write4),
        .mem_to_reg(mem_to_reg4), .reg_dst(reg_dst4), .reg_write(reg_write4),
        .alu_src_a(alu_src_a4), .alu_src_b(alu_src_b4), .alu_op(alu_op4),
        .pc_source(pc_source4), .retired(retired4), .illegal(illegal4)
    );

    // Control word each phase should present, straight from the state table.
    function automatic ctrl_t expect_ctrl(input phase_t p, input logic rdy, input logic rst);
        ctrl_t c;
        c = '0;
        case (p)
            P_FETCH: begin
                c.mem_read  = 1'b1;
                c.alu_src_b = 2'd1;
                c.pc_write  = rdy & ~rst;
                c.ir_write  = rdy & ~rst;
            end
            P_DECODE:    c.alu_src_b = 2'd3;
            P_MEM_ADDR:  begin c.alu_src_a = 1'b1; c.alu_src_b = 2'd2; end
            P_MEM_READ:  begin c.mem_read = 1'b1; c.i_or_d = 1'b1; end
            P_MEM_WB:    begin c.reg_write = 1'b1; c.mem_to_reg = 1'b1; end
            P_MEM_WRITE: begin c.mem_write = 1'b1; c.i_or_d = 1'b1; end
            P_R_EXEC:    begin c.alu_src_a = 1'b1; c.alu_op = 2'd2; end
            P_R_WB:      begin c.reg_write = 1'b1; c.reg_dst = 1'b1; end
            P_ADDI_EXEC: begin c.alu_src_a = 1'b1; c.alu_src_b = 2'd2; end
            P_ADDI_WB:   c.reg_write = 1'b1;
            P_BRANCH: begin
                c.alu_src_a = 1'b1; c.alu_op = 2'd1;
                c.pc_write_cond = 1'b1; c.pc_source = 2'd1;
            end
            P_JUMP:      begin c.pc_write = 1'b1; c.pc_source = 2'd2; end
            default: ;
        endcase
        return c;
    endfunction

    // Phase sequence an opcode walks through; length 2 means illegal.
    function automatic int plan(input logic [5:0] op, output phase_t ph [5]);
        ph[0] = P_FETCH; ph[1] = P_DECODE;
        ph[2] = P_FETCH; ph[3] = P_FETCH; ph[4] = P_FETCH;
        case (op)
            6'h23: begin ph[2] = P_MEM_ADDR; ph[3] = P_MEM_READ; ph[4] = P_MEM_WB; return 5; end
            6'h2B: begin ph[2] = P_MEM_ADDR; ph[3] = P_MEM_WRITE; return 4; end
            6'h00: begin ph[2] = P_R_EXEC; ph[3] = P_R_WB; return 4; end
            6'h08: begin ph[2] = P_ADDI_EXEC; ph[3] = P_ADDI_WB; return 4; end
            6'h04: begin ph[2] = P_BRANCH; return 3; end
            6'h02: begin ph[2] = P_JUMP; return 3; end
            default: return 2;
        endcase
    endfunction

    task automatic drive(input phase_t p, input logic rdy, input logic [5:0] op);
        exp_t e;
        opcode    = op;
        mem_ready = rdy;
        e.ctrl    = expect_ctrl(p, rdy, 1'b0);
        e.retired = model_cnt;
        e.illegal = model_ill;
        q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input logic rdy);
        exp_t e;
        reset     = 1'b1;
        mem_ready = rdy;
        model_cnt = 0;
        model_ill = 1'b0;
        e.ctrl    = expect_ctrl(P_FETCH, rdy, 1'b1);
        e.retired = 0;
        e.illegal = 1'b0;
        q.push_back(e);
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    // One instruction; abort_at >= 0 replaces that cycle with a reset.
    task automatic issue(input logic [5:0] op, input int fstall, input int mstall, input int abort_at);
        phase_t ph [5];
        int     n;
        int     cyc;
        int     waits;
        bit     waitable;
        logic   rdy;
        n   = plan(op, ph);
        cyc = 0;
        for (int i = 0; i < n; i++) begin
            waitable = (ph[i] == P_FETCH) || (ph[i] == P_MEM_READ) || (ph[i] == P_MEM_WRITE);
            waits    = (ph[i] == P_FETCH) ? fstall : (waitable ? mstall : 0);
            for (int k = 0; k <= waits; k++) begin
                rdy = waitable ? (k == waits) : 1'($urandom_range(0, 1));
                if (cyc == abort_at) begin
                    do_reset(1'($urandom_range(0, 1)));
                    return;
                end
                drive(ph[i], rdy, op);
                cyc++;
            end
            if (ph[i] == P_DECODE && n == 2) model_ill = 1'b1;
        end
        if (n > 2) model_cnt++;
    endtask

    // Monitor: one expected record per cycle, sampled mid-cycle.
    exp_t  mon_e;
    ctrl_t mon_a;
    ctrl_t mon_a4;
    initial begin
        forever begin
            @(negedge clk);
            if (q.size() != 0) begin
                mon_e  = q.pop_front();
                mon_a  = {pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
                          mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op, pc_source};
                mon_a4 = {pc_write4, pc_write_cond4, i_or_d4, mem_read4, mem_write4, ir_write4,
                          mem_to_reg4, reg_dst4, reg_write4, alu_src_a4, alu_src_b4, alu_op4, pc_source4};
                n_vec++;
                if (mon_a !== mon_e.ctrl || mon_a4 !== mon_e.ctrl || retired !== mon_e.retired ||
                    retired4 !== mon_e.retired[3:0] || illegal !== mon_e.illegal ||
                    illegal4 !== mon_e.illegal) begin
                    n_err++;
                    $display("FAIL vec %0d t=%0t: ctrl got %h/%h want %h, retired got %0d/%0d want %0d/%0d, illegal got %b/%b want %b",
                             n_vec, $time, mon_a, mon_a4, mon_e.ctrl, retired, retired4,
                             mon_e.retired, mon_e.retired[3:0], illegal, illegal4, mon_e.illegal);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [5:0] op;
        reset     = 1'b1;
        mem_ready = 1'b0;
        opcode    = 6'h00;
        model_cnt = 0;
        model_ill = 1'b0;
        @(posedge clk);
        #1;
        do_reset(1'b1);

        // Directed: plain stream, stalled lw, stalled fetch, illegal, aborted sw, wrap.
        issue(6'h00, 0, 0, -1);
        issue(6'h23, 0, 0, -1);
        issue(6'h2B, 0, 0, -1);
        issue(6'h04, 0, 0, -1);
        issue(6'h02, 0, 0, -1);
        issue(6'h08, 0, 0, -1);
        issue(6'h23, 0, 3, -1);
        issue(6'h00, 2, 0, -1);
        issue(6'h3F, 0, 0, -1);
        issue(6'h08, 0, 0, -1);
        issue(6'h2B, 0, 2, 4);
        for (int i = 0; i < 17; i++) issue(6'h02, 0, 0, -1);

        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 9) < 8) op = legal_ops[$urandom_range(0, 5)];
            else                          op = 6'($urandom_range(0, 63));
            issue(op,
                  ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 3)) : 0,
                  ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 3)) : 0,
                  ($urandom_range(0, 19) == 0) ? int'($urandom_range(0, 6)) : -1);
        end

        @(negedge clk);
        n_vec++;
        if (q.size() != 0) begin
            n_err++;
            $display("FAIL drain: got %0d unchecked records, want 0", q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
